// File: rtl/avalon_pkg.sv
// Shared types and defaults for the Avalon-MM master engine.
package avalon_pkg;

  localparam int unsigned AVM_ADDR_W      = 32;
  localparam int unsigned AVM_DATA_W      = 32;
  localparam int unsigned AVM_TIMEOUT_DEF = 1023;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } avm_state_t;

  // States in which a bus transfer is outstanding.
  function automatic logic is_busy(input avm_state_t s);
    return (s == RD_REQ) || (s == RD_WAIT) || (s == WR_REQ);
  endfunction

endpackage

// File: rtl/avalon_timeout_ctr.sv
// Stall watchdog: counts busy cycles and flags the cycle in which the limit is hit.
module avalon_timeout_ctr
  import avalon_pkg::*;
#(
  parameter int unsigned TIMEOUT = AVM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset_n, clr, en};
    assign expired       = 1'b0;
  end else begin : g_on
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating count of busy cycles since the last clear.
    always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
        cnt_d = '0;
      end else if (en && (cnt_q != CNT_W'(TIMEOUT))) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // The current busy cycle is the TIMEOUT-th one: abort at its closing edge.
    assign expired = en && !clr && (cnt_q == CNT_W'(TIMEOUT - 1));
  end

endmodule

// File: rtl/avalon_mm_master.sv
// Single-transfer Avalon-MM master driven by a four-phase start/done handshake.
module avalon_mm_master
  import avalon_pkg::*;
#(
  parameter int unsigned ADDR_W  = AVM_ADDR_W,
  parameter int unsigned DATA_W  = AVM_DATA_W,
  parameter bit          USE_RDV = 1'b1,
  parameter int unsigned TIMEOUT = AVM_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   dataWrite,
  output logic [DATA_W-1:0]   dataRead,
  output logic                done,
  output logic                busy,
  output logic                err,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid
);

  avm_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;

  logic              tmo_clr;
  logic              tmo_en;
  logic              tmo_expired;

  avalon_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_clr = 1'b0;
    tmo_en  = is_busy(state_q);

    case (state_q)
      IDLE: begin
        tmo_clr = 1'b1;
        if (start) begin
          if (read ^ write) begin
            err_d  = 1'b0;
            addr_d = address;
            if (write) begin
              wdata_d = dataWrite;
              state_d = WR_REQ;
            end else begin
              state_d = RD_REQ;
            end
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      RD_REQ: begin
        // An accepted command wins over an expiry landing in the same cycle.
        if (!avm_waitrequest) begin
          if (!USE_RDV || avm_readdatavalid) begin
            rdata_d = avm_readdata;
            state_d = DONE;
          end else begin
            state_d = RD_WAIT;
          end
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      RD_WAIT: begin
        if (avm_readdatavalid) begin
          rdata_d = avm_readdata;
          state_d = DONE;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      WR_REQ: begin
        if (!avm_waitrequest) begin
          state_d = DONE;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    rd_d   = (state_d == RD_REQ);
    wr_d   = (state_d == WR_REQ);
    done_d = (state_d == DONE);
    busy_d = is_busy(state_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign dataRead       = rdata_q;
  assign done           = done_q;
  assign busy           = busy_q;
  assign err            = err_q;
  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = '1;

endmodule

// File: doc/avalon_mm_master.md
Name: avalon_mm_master

Overview:
- Avalon-MM master engine that sits directly downstream of the debug/uP interconnect, one instance per bus (external data, instruction).
- Consumes the interconnect's start/read/write/address/write-data, and runs exactly one Avalon-MM transfer per request.
- Honours waitrequest and, optionally, readdatavalid.
- Returns read data and a level done, which the interconnect uses to drop start (four-phase handshake).

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
USE_RDV, 1, 1 = pipelined reads (wait for avm_readdatavalid); 0 = data sampled when waitrequest drops
TIMEOUT, 1023, max cycles a transfer may stall before abort; 0 disables the timeout

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  request; level, held by the interconnect until done seen
read  in  1  request is a read
write  in  1  request is a write
address  in  ADDR_W  byte address of the transfer
dataWrite  in  DATA_W  write data
dataRead  out  DATA_W  last read data
done  out  1  transfer finished; held while start high
busy  out  1  transfer in progress
err  out  1  last transfer aborted (timeout or illegal request)
avm_address  out  ADDR_W  Avalon address
avm_read  out  1  Avalon read
avm_write  out  1  Avalon write
avm_writedata  out  DATA_W  Avalon write data
avm_byteenable  out  DATA_W/8  all ones
avm_waitrequest  in  1  slave stall
avm_readdata  in  DATA_W  slave read data
avm_readdatavalid  in  1  read data valid (used only when USE_RDV=1)

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0 except avm_byteenable (all ones). Also cleared: dataRead, internal latches, timeout counter. Takes effect mid-transfer; avm_read/avm_write drop immediately.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE, start=1 sampled at an edge:
  - read=1, write=0: latch address, go to RD_REQ.
  - write=1, read=0: latch address and dataWrite, go to WR_REQ.
  - read=write=1 or read=write=0: go straight to DONE with err=1; no bus cycle.
- Latched values only are driven on avm_address/avm_writedata. Input changes during a transfer are ignored.
- RD_REQ: avm_read=1, held until a cycle with avm_waitrequest=0.
  - USE_RDV=0: avm_readdata is captured into dataRead at that edge; go to DONE.
  - USE_RDV=1: go to RD_WAIT, avm_read=0. A readdatavalid arriving in the same cycle as the accepting edge is also accepted: capture and go to DONE.
- RD_WAIT: on avm_readdatavalid=1, capture avm_readdata and go to DONE.
- WR_REQ: avm_write=1 until avm_waitrequest=0; then go to DONE.
- DONE:
  - done=1, busy=0.
  - Stays in DONE while start=1; when start=0, go to IDLE the next edge (done falls).
  - err is held through DONE and cleared on the next accepted start.
- busy=1 in RD_REQ, RD_WAIT, WR_REQ.
- Latency, zero wait states:
  - USE_RDV=0: start sampled at edge N, avm_read/avm_write high in cycle N+1, done high in cycle N+2.
  - USE_RDV=1: done follows readdatavalid by one cycle.
- Timeout:
  - Counter is cleared on entering a busy state and increments each busy cycle.
  - When it reaches TIMEOUT: drop avm_read/avm_write, err=1, go to DONE; dataRead unchanged.
  - A late readdatavalid after an abort is ignored.
- start rising while busy or in DONE has no effect.
- dataRead holds its value until the next successful read.

Decomposition:
- Package avalon_pkg: typedef enum logic [2:0] avm_state_t {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE}; constants AVM_ADDR_W=32, AVM_DATA_W=32, AVM_TIMEOUT_DEF=1023.
- One sub-module, avalon_timeout_ctr:
  - Inputs: clk, reset_n, clr, en. Output: expired.
  - Width is $clog2(TIMEOUT+1); expired is tied to 0 when TIMEOUT=0.

Test Plan:
- Zero-wait read, USE_RDV=0: start/read, address=0x100, avm_readdata=0xCAFE0001, waitrequest=0 -> avm_read high 1 cycle with avm_address=0x100; dataRead=0xCAFE0001; done 2 cycles after start; done falls 1 cycle after start drops.
- Stalled write: dataWrite=0x12345678, address=0x40, waitrequest high 3 cycles -> avm_write high exactly 4 cycles with avm_writedata=0x12345678 stable; done the next cycle; err=0.
- Pipelined read, USE_RDV=1: waitrequest=0, readdatavalid 5 cycles later with data 0xA5A5A5A5 -> avm_read high 1 cycle; busy through the wait; dataRead=0xA5A5A5A5; done 1 cycle after rdv.
- Timeout, TIMEOUT=8: waitrequest held high -> avm_read drops after 8 busy cycles; err=1, done=1; dataRead keeps its old value; a later rdv is ignored.
- Illegal request: read=write=1 with start -> no avm_read/avm_write; done=1, err=1 the next cycle. Then a legal read clears err.
- Reset mid-transfer: reset_n low during WR_REQ -> avm_write, busy, done drop asynchronously. After release, state is IDLE and the next start works normally.
